// File: rtl/dma_channel_scheduler_if.sv
// Avalon-MM master bundle between the channel scheduler and the DMA controller CSR slave.
interface dma_channel_scheduler_if;
  logic        oAvm_chipselect;
  logic        oAvm_read;
  logic        oAvm_write;
  logic [2:0]  oAvm_address;
  logic [31:0] oAvm_writedata;
  logic [31:0] iAvm_readdata;
  logic        iAvm_waitrequest;

  modport master (
    output oAvm_chipselect, oAvm_read, oAvm_write, oAvm_address, oAvm_writedata,
    input  iAvm_readdata, iAvm_waitrequest
  );

  modport slave (
    input  oAvm_chipselect, oAvm_read, oAvm_write, oAvm_address, oAvm_writedata,
    output iAvm_readdata, iAvm_waitrequest
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Two-channel round-robin DMA scheduler: programs a DMA controller over Avalon-MM,
// polls its done bit, and reports per-channel completion or timeout.
module dma_channel_scheduler #(
  parameter int unsigned POLL_GAP      = 4,
  parameter int unsigned TIMEOUT_POLLS = 1024
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [1:0]  iReq,
  input  logic [63:0] iSrc,
  input  logic [63:0] iDst,
  input  logic [63:0] iLen,
  output logic [1:0]  oAck,
  output logic [1:0]  oErr,
  output logic        oBusy,
  output logic [1:0]  oGrant,
  dma_channel_scheduler_if.master avm
);

  localparam int unsigned W_DATA = 32;
  localparam int unsigned W_ADDR = 3;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned POLL_W = $clog2(TIMEOUT_POLLS + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WR_SRC    = 4'd1;
  localparam logic [3:0] S_WR_DST    = 4'd2;
  localparam logic [3:0] S_WR_LEN    = 4'd3;
  localparam logic [3:0] S_WR_START  = 4'd4;
  localparam logic [3:0] S_POLL_WAIT = 4'd5;
  localparam logic [3:0] S_POLL_RD   = 4'd6;
  localparam logic [3:0] S_DONE      = 4'd7;
  localparam logic [3:0] S_ABORT     = 4'd8;

  logic [3:0]        r_state, w_state_nxt;
  logic [W_DATA-1:0] r_src, r_dst, r_len, w_src_nxt, w_dst_nxt, w_len_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic              r_last, w_last_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [POLL_W-1:0] r_polls, w_polls_nxt, w_polls_inc;
  logic [1:0]        r_ack, r_err;
  logic              r_busy;
  logic              r_cs, r_rd, r_wr, w_cs, w_rd, w_wr;
  logic [W_ADDR-1:0] r_addr, w_addr;
  logic [W_DATA-1:0] r_wdata, w_wdata;
  logic              w_sel;
  logic [W_DATA-1:0] w_src_sel, w_dst_sel, w_len_sel;
  logic              w_unused_rdata;

  // Round-robin pick: on contention the channel not granted last wins
  assign w_sel     = (iReq == 2'b11) ? ~r_last : iReq[1];
  assign w_src_sel = w_sel ? iSrc[63:32] : iSrc[31:0];
  assign w_dst_sel = w_sel ? iDst[63:32] : iDst[31:0];
  assign w_len_sel = w_sel ? iLen[63:32] : iLen[31:0];
  assign w_polls_inc    = r_polls + POLL_W'(1);
  assign w_unused_rdata = ^avm.iAvm_readdata[31:1];

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_gap_nxt   = r_gap;
    w_polls_nxt = r_polls;
    case (r_state)
      // A completion pulse in flight holds off re-arbitration for one IDLE cycle
      S_IDLE: if ((iReq != 2'b00) && ((r_ack | r_err) == 2'b00)) begin
        w_grant_nxt = w_sel ? 2'b10 : 2'b01;
        w_src_nxt   = w_src_sel;
        w_dst_nxt   = w_dst_sel;
        w_len_nxt   = w_len_sel;
        w_gap_nxt   = '0;
        w_polls_nxt = '0;
        w_state_nxt = (w_len_sel == '0) ? S_DONE : S_WR_SRC;
      end
      S_WR_SRC:   if (!avm.iAvm_waitrequest) w_state_nxt = S_WR_DST;
      S_WR_DST:   if (!avm.iAvm_waitrequest) w_state_nxt = S_WR_LEN;
      S_WR_LEN:   if (!avm.iAvm_waitrequest) w_state_nxt = S_WR_START;
      S_WR_START: if (!avm.iAvm_waitrequest) begin
        w_state_nxt = S_POLL_WAIT;
        w_gap_nxt   = '0;
      end
      S_POLL_WAIT: begin
        if (r_gap == GAP_W'(POLL_GAP - 1)) begin
          w_state_nxt = S_POLL_RD;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      S_POLL_RD: if (!avm.iAvm_waitrequest) begin
        if (avm.iAvm_readdata[0]) begin
          w_state_nxt = S_DONE;
        end else if (w_polls_inc == POLL_W'(TIMEOUT_POLLS)) begin
          w_state_nxt = S_ABORT;
        end else begin
          w_polls_nxt = w_polls_inc;
          w_state_nxt = S_POLL_WAIT;
        end
      end
      S_DONE, S_ABORT: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 2'b00;
        w_last_nxt  = r_grant[1];
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so they line up with it
    w_cs    = 1'b0;
    w_rd    = 1'b0;
    w_wr    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    case (w_state_nxt)
      S_WR_SRC:   begin w_cs = 1'b1; w_wr = 1'b1; w_addr = W_ADDR'(0); w_wdata = w_src_nxt; end
      S_WR_DST:   begin w_cs = 1'b1; w_wr = 1'b1; w_addr = W_ADDR'(1); w_wdata = w_dst_nxt; end
      S_WR_LEN:   begin w_cs = 1'b1; w_wr = 1'b1; w_addr = W_ADDR'(2); w_wdata = w_len_nxt; end
      S_WR_START: begin w_cs = 1'b1; w_wr = 1'b1; w_addr = W_ADDR'(3); w_wdata = W_DATA'(1); end
      S_POLL_RD:  begin w_cs = 1'b1; w_rd = 1'b1; w_addr = W_ADDR'(4); end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
      r_gap   <= '0;
      r_polls <= '0;
      r_ack   <= 2'b00;
      r_err   <= 2'b00;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_src   <= w_src_nxt;
      r_dst   <= w_dst_nxt;
      r_len   <= w_len_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_gap   <= w_gap_nxt;
      r_polls <= w_polls_nxt;
      r_ack   <= (r_state == S_DONE)  ? r_grant : 2'b00;
      r_err   <= (r_state == S_ABORT) ? r_grant : 2'b00;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_cs    <= w_cs;
      r_rd    <= w_rd;
      r_wr    <= w_wr;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
    end
  end

  assign oAck   = r_ack;
  assign oErr   = r_err;
  assign oBusy  = r_busy;
  assign oGrant = r_grant;
  assign avm.oAvm_chipselect = r_cs;
  assign avm.oAvm_read       = r_rd;
  assign avm.oAvm_write      = r_wr;
  assign avm.oAvm_address    = r_addr;
  assign avm.oAvm_writedata  = r_wdata;

endmodule
